// File: rtl/irq_arbiter.sv
// irq_arbiter: arbitrates N level-sensitive interrupt sources onto a single core
// interrupt line. It supports fixed-priority or round-robin selection, and has a
// small register block on the system bus.
//
// Ports:
//   clk_i          system clock, all logic on posedge
//   rst_i          synchronous active-high reset
//   req_i          bus request
//   write_enable_i bus write (1) / read (0)
//   addr_i         block-relative byte address
//   write_data_i   bus write data
//   read_data_o    registered bus read data
//   irq_src_i      level interrupt requests from peripherals
//   irq_ret_o      one-cycle return pulse to the granted peripheral
//   irq_o          interrupt request to core
//   irq_id_o       index of granted source (0 when irq_o=0)
//   mret_i         core interrupt-return pulse
//
// Register map: 0x00 MASK (RW), 0x04 PENDING (RO), 0x08 ACTIVE (RO), 0x0C MODE (RW).
module irq_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic          write_enable_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   write_data_i,
  output logic [31:0]   read_data_o,
  input  logic [N-1:0]  irq_src_i,
  output logic [N-1:0]  irq_ret_o,
  output logic          irq_o,
  output logic [3:0]    irq_id_o,
  input  logic          mret_i
);

  localparam int unsigned DW  = 32;
  localparam int unsigned IDW = 4;

  localparam logic [DW-1:0]  ADDR_MASK   = 32'h0000_0000;
  localparam logic [DW-1:0]  ADDR_PEND   = 32'h0000_0004;
  localparam logic [DW-1:0]  ADDR_ACTIVE = 32'h0000_0008;
  localparam logic [DW-1:0]  ADDR_MODE   = 32'h0000_000C;
  localparam logic [IDW-1:0] LAST_ID     = IDW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RET    = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   mask_q, mask_d;
  logic           mode_q, mode_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic           irq_q, irq_d;
  logic [IDW-1:0] irq_id_q, irq_id_d;
  logic [N-1:0]   ret_q, ret_d;
  logic [DW-1:0]  rdata_q, rdata_d;

  logic [N-1:0]   pend_c;
  logic [IDW-1:0] low_c;
  logic [IDW-1:0] high_c;
  logic           high_found_c;
  logic [IDW-1:0] win_c;
  logic           unused_wdata_c;

  // Upper write-data bits have no register storage.
  assign unused_wdata_c = ^write_data_i[DW-1:N];

  assign pend_c = irq_src_i & mask_q;

  // Winner select: lowest set index overall, and lowest set index at or above
  // the round-robin pointer. Descending loop so the last hit is the lowest.
  always_comb begin
    low_c        = '0;
    high_c       = '0;
    high_found_c = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_c[i]) begin
        low_c = IDW'(i);
        if (IDW'(i) >= ptr_q) begin
          high_c       = IDW'(i);
          high_found_c = 1'b1;
        end
      end
    end
    // Round-robin falls back to the lowest index when nothing is at/above P (wrap).
    win_c = (mode_q && high_found_c) ? high_c : low_c;
  end

  // Next-state, register block and registered-output logic.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    rdata_d = rdata_q;

    if (req_i && write_enable_i) begin
      case (addr_i)
        ADDR_MASK: mask_d = write_data_i[N-1:0];
        ADDR_MODE: mode_d = write_data_i[0];
        default:   ;
      endcase
    end

    if (req_i && !write_enable_i) begin
      case (addr_i)
        ADDR_MASK:   rdata_d = DW'(mask_q);
        ADDR_PEND:   rdata_d = DW'(pend_c);
        ADDR_ACTIVE: rdata_d = {(state_q == ACTIVE), 27'b0,
                                (state_q == ACTIVE) ? id_q : 4'b0};
        ADDR_MODE:   rdata_d = DW'(mode_q);
        default:     rdata_d = '0;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (|pend_c) begin
          id_d    = win_c;
          state_d = ACTIVE;
          if (mode_q) begin
            ptr_d = (win_c == LAST_ID) ? '0 : win_c + IDW'(1);
          end
        end
      end
      ACTIVE: begin
        if (mret_i) begin
          state_d = RET;
        end
      end
      RET:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    irq_d    = (state_d == ACTIVE);
    irq_id_d = (state_d == ACTIVE) ? id_d : '0;
    ret_d    = (state_d == RET) ? (N'(1) << id_d) : '0;
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      mode_q   <= 1'b0;
      ptr_q    <= '0;
      id_q     <= '0;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
      ret_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
      ret_q    <= ret_d;
      rdata_q  <= rdata_d;
    end
  end

  assign read_data_o = rdata_q;
  assign irq_o       = irq_q;
  assign irq_id_o    = irq_id_q;
  assign irq_ret_o   = ret_q;

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 SHALL have parameter: N, 8, number of interrupt sources (2..16).
REQ-002 SHALL have port: clk_i  input  1  single system clock; all logic on posedge.
REQ-003 SHALL have port: rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_i  input  1  system-bus request.
REQ-005 SHALL have port: write_enable_i  input  1  bus write (1) / read (0).
REQ-006 SHALL have port: addr_i  input  32  bus byte address, block-relative.
REQ-007 SHALL have port: write_data_i  input  32  bus write data.
REQ-008 SHALL have port: read_data_o  output  32  registered bus read data.
REQ-009 SHALL have port: irq_src_i  input  N  level interrupt requests from peripherals (e.g. PS/2, UART, timer).
REQ-010 SHALL have port: irq_ret_o  output  N  one-cycle return pulse to the granted peripheral.
REQ-011 SHALL have port: irq_o  output  1  single interrupt request to core.
REQ-012 SHALL have port: irq_id_o  output  4  index of granted source, valid while irq_o=1.
REQ-013 SHALL have port: mret_i  input  1  core interrupt-return pulse.

Function
REQ-014 SHALL implement registers: 0x00 MASK (RW, bits N-1:0), 0x04 PENDING (RO, irq_src_i & MASK), 0x08 ACTIVE (RO, bit31=grant valid, bits3:0=id), 0x0C MODE (RW, bit0: 0=fixed, 1=round-robin).
REQ-015 SHALL update read_data_o one cycle after req_i=1, write_enable_i=0; unmapped addresses read 0; read_data_o holds value otherwise.
REQ-016 SHALL take writes in the same cycle as req_i=1, write_enable_i=1; writes to RO or unmapped addresses ignored; unused bits read 0.
REQ-017 SHALL use FSM states IDLE, ACTIVE, RET.
REQ-018 IDLE: if (irq_src_i & MASK) != 0, select winner, latch id, next state ACTIVE; else stay.
REQ-019 Fixed mode: winner = lowest set index.
REQ-020 Round-robin mode: winner = first set index at or above pointer P, wrapping N-1 -> 0; on grant P <= (id+1) mod N.
REQ-021 ACTIVE: irq_o=1, irq_id_o=latched id; stay until mret_i=1, then RET.
REQ-022 RET: irq_ret_o[id]=1 for exactly this cycle, irq_o=0, next state IDLE; new arbitration occurs only in IDLE (grant-to-grant gap at least 2 cycles after mret_i).
REQ-023 Grant latency: irq_o rises 1 cycle after an unmasked request is visible in IDLE.
REQ-024 mret_i in IDLE or RET SHALL be ignored.
REQ-025 Source deasserting or being masked while ACTIVE SHALL NOT cancel the grant.
REQ-026 MASK/MODE writes take effect for the next IDLE arbitration; a MODE change does not reset P.
REQ-027 irq_ret_o SHALL be zero in all states except RET; at most one bit set.
REQ-028 irq_id_o SHALL read 0 when irq_o=0.

Reset
REQ-029 On rst_i=1 at a clock edge: state IDLE, MASK=0, MODE=0, P=0, irq_o=0, irq_id_o=0, irq_ret_o=0, read_data_o=0.
REQ-030 Reset during ACTIVE or RET SHALL abort the grant with no irq_ret_o pulse.

Verification
REQ-031 Reset, MASK=0, irq_src_i=0x05 -> irq_o stays 0; read 0x04 -> 0x0.
REQ-032 MASK=0xFF, MODE=0, irq_src_i=0x0A -> irq_o=1, irq_id_o=1 next cycle; mret_i pulse -> irq_ret_o=0x02 for one cycle; with 0x0A still high, next grant id=1 again.
REQ-033 MODE=1, MASK=0xFF, irq_src_i=0x81 held, mret after each grant -> grant ids 0,7,0,7.
REQ-034 While ACTIVE id=3, write MASK=0x00 and drop irq_src_i[3] -> irq_o stays 1 until mret_i; irq_ret_o=0x08 on return.
REQ-035 Grant id=2 active, assert rst_i one cycle -> irq_o=0 next edge, irq_ret_o never pulses, MASK reads 0.
REQ-036 mret_i pulsed in IDLE with no requests -> no state change, irq_ret_o=0; read 0x08 -> 0x0.
